// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and parameter checks for the bit-serial add/subtract controller.
package serial_adder_ctrl_pkg;

    localparam int unsigned MIN_WIDTH = 1;
    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic bit width_ok(input int unsigned w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between a requester and the serial adder controller.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_start;
    logic             in_sub;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_ready;
    logic             out_busy;
    logic             out_done;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_start, in_sub, in_a, in_b, in_cin,
        input  out_ready, out_busy, out_done, out_sum, out_cout
    );

    modport slave (
        input  in_start, in_sub, in_a, in_b, in_cin,
        output out_ready, out_busy, out_done, out_sum, out_cout
    );

endinterface

// File: rtl/fullAdder.sv
// One-bit full adder composed of two half adders.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    halfAdder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    halfAdder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/halfAdder.sv
// One-bit half adder, the leaf cell of the existing adder datapath.
module halfAdder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Time-shares one fullAdder to add/subtract two WIDTH-bit operands LSB first,
// one bit per clock, behind a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    serial_adder_ctrl_if.slave bus
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("serial_adder_ctrl: WIDTH must be in 1..32");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_shift;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    fullAdder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB; shift form also covers WIDTH == 1.
    always_comb begin
        res_shift = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_a          <= '0;
            op_b          <= '0;
            res           <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_done  <= 1'b0;
            bus.out_busy  <= 1'b0;
            bus.out_ready <= 1'b1;
        end else begin
            bus.out_done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.in_start) begin
                        // Subtraction as A + ~B + 1.
                        op_a          <= bus.in_a;
                        op_b          <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry         <= bus.in_sub ? 1'b1 : bus.in_cin;
                        res           <= '0;
                        cnt           <= '0;
                        state         <= ST_RUN;
                        bus.out_busy  <= 1'b1;
                        bus.out_ready <= 1'b0;
                    end else begin
                        state         <= ST_IDLE;
                        bus.out_busy  <= 1'b0;
                        bus.out_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    res   <= res_shift;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        bus.out_sum   <= res_shift;
                        bus.out_cout  <= fa_c;
                        bus.out_done  <= 1'b1;
                        bus.out_busy  <= 1'b0;
                        bus.out_ready <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to the reset condition.
                    state         <= ST_IDLE;
                    op_a          <= '0;
                    op_b          <= '0;
                    res           <= '0;
                    carry         <= 1'b0;
                    cnt           <= '0;
                    bus.out_sum   <= '0;
                    bus.out_cout  <= 1'b0;
                    bus.out_busy  <= 1'b0;
                    bus.out_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8) with hand-computed vectors.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   done_cnt;
    int   issued;
    exp_t exp_q[$];

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got sum 0x%0h with no pending result", bus.out_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum", 32'(bus.out_sum), 32'(e.sum));
                    check("sb_cout", 32'(bus.out_cout), 32'(e.cout));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.out_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (bus.out_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: got ready=%b after 40 cycles, expected 1", name, bus.out_ready);
        end
    endtask

    task automatic issue(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic [WIDTH-1:0] esum, input logic ecout);
        exp_t e;
        wait_ready("issue_ready");
        bus.in_start = 1'b1;
        bus.in_sub   = sub;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        e.sum  = esum;
        e.cout = ecout;
        exp_q.push_back(e);
        issued++;
        tick();
        bus.in_start = 1'b0;
    endtask

    task automatic run_op(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] esum, input logic ecout);
        issue(sub, a, b, cin, esum, ecout);
        wait_ready("complete_ready");
    endtask

    initial begin
        int n;
        int done_before;
        exp_t e;
        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        issued   = 0;
        reset        = 1'b1;
        bus.in_start = 1'b0;
        bus.in_sub   = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_cin   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(bus.out_ready), 32'd1);
        check("rst_busy", 32'(bus.out_busy), 32'd0);
        check("rst_done", 32'(bus.out_done), 32'd0);
        check("rst_sum", 32'(bus.out_sum), 32'd0);
        check("rst_cout", 32'(bus.out_cout), 32'd0);

        // Basic adds, wrap-around and carry-in.
        issue(1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        n = 0;
        while (bus.out_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("latency_edges_after_accept", 32'(n + 1), 32'd9);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Subtraction: cout=1 means no borrow; cin must be ignored.
        run_op(1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_op(1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
        run_op(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Start during RUN is ignored; busy lasts exactly WIDTH cycles.
        tick();
        tick();
        done_before = done_cnt;
        issue(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        n = 0;
        while (bus.out_busy === 1'b1 && n < 20) begin
            n++;
            if (n == 3) begin
                bus.in_start = 1'b1;
                bus.in_a     = 8'hAA;
                bus.in_b     = 8'h55;
            end
            tick();
            if (n == 3) bus.in_start = 1'b0;
        end
        check("busy_cycles", 32'(n), 32'd8);
        @(negedge clk);
        #1;
        check("single_done", 32'(done_cnt - done_before), 32'd1);
        tick();
        tick();
        tick();
        check("hold_sum", 32'(bus.out_sum), 32'h02);
        check("hold_done_low", 32'(bus.out_done), 32'd0);
        check("idle_ready", 32'(bus.out_ready), 32'd1);

        // Reset at E4 aborts the operation without a done pulse.
        done_before = done_cnt;
        issue(1'b0, 8'h22, 8'h11, 1'b0, 8'h33, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e = exp_q.pop_back();
        issued--;
        check("abort_ready", 32'(bus.out_ready), 32'd1);
        check("abort_busy", 32'(bus.out_busy), 32'd0);
        check("abort_done", 32'(bus.out_done), 32'd0);
        check("abort_sum", 32'(bus.out_sum), 32'd0);
        check("abort_cout", 32'(bus.out_cout), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_no_done", 32'(done_cnt - done_before), 32'd0);
        run_op(1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // Start held high: back-to-back, one result every 9 cycles.
        tick();
        wait_ready("b2b_ready");
        for (int i = 0; i < 3; i++) begin
            e.sum  = 8'h07;
            e.cout = 1'b0;
            exp_q.push_back(e);
            issued++;
        end
        bus.in_start = 1'b1;
        bus.in_sub   = 1'b0;
        bus.in_a     = 8'h03;
        bus.in_b     = 8'h04;
        bus.in_cin   = 1'b0;
        tick();
        for (int k = 0; k < 27; k++) begin
            logic eb;
            eb = ((k % 9) != 8);
            check($sformatf("b2b_ready_busy_k%0d", k), 32'({bus.out_ready, bus.out_busy}), 32'({~eb, eb}));
            if (k == 26) bus.in_start = 1'b0;
            tick();
        end
        check("b2b_back_to_idle_ready", 32'(bus.out_ready), 32'd1);

        for (int i = 0; i < 5; i++) tick();
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'(issued));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
